// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    localparam int BEATS_WORD = 4;
    localparam int BEATS_BYTE = 1;

    typedef logic [1:0] beat_t;

    function automatic beat_t last_beat(input logic byte_mode);
        return byte_mode ? beat_t'(BEATS_BYTE - 1) : beat_t'(BEATS_WORD - 1);
    endfunction

endpackage

// File: rtl/load_store_unit.sv
// Serialises pipeline loads/stores into byte-wide memory beats and
// returns assembled load data as a one-cycle response pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int STORE_WIDTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic                     addr_modeM,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]    req_wd,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_rd,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_A,
    output logic [STORE_WIDTH-1:0]   mem_WD,
    input  logic [STORE_WIDTH-1:0]   mem_RD
);

    lsu_state_t state, state_next;

    beat_t                    beat;
    logic                     lat_we;
    logic                     lat_byte;
    logic [ADDRESS_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0]    lat_wd;
    logic [DATA_WIDTH-1:0]    rdata;

    logic accept;
    logic is_last;

    assign accept  = (state == IDLE) && req_valid;
    assign is_last = (beat == last_beat(lat_byte));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (req_valid) state_next = XFER;
            XFER: if (is_last) state_next = RESP;
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request latch, beat counter and load-data assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat     <= '0;
            lat_we   <= 1'b0;
            lat_byte <= 1'b0;
            lat_addr <= '0;
            lat_wd   <= '0;
            rdata    <= '0;
        end else if (accept) begin
            beat     <= '0;
            lat_we   <= req_we;
            lat_byte <= addr_modeM;
            lat_addr <= req_addr;
            lat_wd   <= req_wd;
            rdata    <= '0;
        end else if (state == XFER) begin
            if (!lat_we) begin
                rdata[int'(beat)*STORE_WIDTH +: STORE_WIDTH] <= mem_RD;
            end
            beat <= beat + beat_t'(1);
        end
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = 1'b0;
        rsp_rd    = '0;
        mem_we    = 1'b0;
        mem_A     = '0;
        mem_WD    = '0;
        unique case (state)
            XFER: begin
                mem_we = lat_we;
                mem_A  = lat_addr + {{(ADDRESS_WIDTH-2){1'b0}}, beat};
                mem_WD = lat_wd[int'(beat)*STORE_WIDTH +: STORE_WIDTH];
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (!lat_we) begin
                    if (lat_byte) begin
                        rsp_rd = {{(DATA_WIDTH-STORE_WIDTH){1'b0}},
                                  rdata[STORE_WIDTH-1:0]};
                    end else begin
                        rsp_rd = rdata;
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small byte memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        addr_modeM;
    logic [31:0] req_addr;
    logic [31:0] req_wd;
    logic        rsp_valid;
    logic [31:0] rsp_rd;
    logic        mem_we;
    logic [31:0] mem_A;
    logic [7:0]  mem_WD;
    logic [7:0]  mem_RD;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];

    always #5 clk = ~clk;

    assign mem_RD = mem[mem_A[7:0]];

    always @(posedge clk) begin
        if (mem_we) mem[mem_A[7:0]] <= mem_WD;
    end

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .addr_modeM (addr_modeM),
        .req_addr   (req_addr),
        .req_wd     (req_wd),
        .rsp_valid  (rsp_valid),
        .rsp_rd     (rsp_rd),
        .mem_we     (mem_we),
        .mem_A      (mem_A),
        .mem_WD     (mem_WD),
        .mem_RD     (mem_RD)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic bm,
                         input logic [31:0] a, input logic [31:0] wd);
        req_valid  = 1'b1;
        req_we     = we;
        addr_modeM = bm;
        req_addr   = a;
        req_wd     = wd;
    endtask

    logic [31:0] exp_a [4];
    logic [7:0]  exp_b [4];

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        addr_modeM = 1'b0;
        req_addr   = '0;
        req_wd     = '0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h11;
        mem[8'h01] = 8'h22;
        mem[8'h02] = 8'h33;
        mem[8'h03] = 8'h44;
        mem[8'hFE] = 8'hAA;
        mem[8'hFF] = 8'hBB;

        // Reset state
        tick();
        tick();
        check("rst_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_rd", rsp_rd, 32'd0);
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_mem_A", mem_A, 32'd0);
        check("rst_mem_WD", {24'b0, mem_WD}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Word load @0x10000
        issue(1'b0, 1'b0, 32'h0001_0000, 32'h0);
        tick();
        req_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            check("wl_mem_A", mem_A, 32'h0001_0000 + b);
            check("wl_mem_we", {31'b0, mem_we}, 32'd0);
            check("wl_ready_busy", {31'b0, req_ready}, 32'd0);
            check("wl_no_rsp", {31'b0, rsp_valid}, 32'd0);
            tick();
        end
        check("wl_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("wl_rsp_rd", rsp_rd, 32'h4433_2211);
        check("wl_mem_A_idle", mem_A, 32'd0);
        tick();
        check("wl_pulse_end", {31'b0, rsp_valid}, 32'd0);
        check("wl_ready_back", {31'b0, req_ready}, 32'd1);

        // Byte load @0x10002
        issue(1'b0, 1'b1, 32'h0001_0002, 32'h0);
        tick();
        req_valid = 1'b0;
        check("bl_mem_A", mem_A, 32'h0001_0002);
        check("bl_no_rsp", {31'b0, rsp_valid}, 32'd0);
        tick();
        check("bl_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("bl_rsp_rd", rsp_rd, 32'h0000_0033);
        tick();

        // Word store 0xDEADBEEF @0x20
        exp_b[0] = 8'hEF;
        exp_b[1] = 8'hBE;
        exp_b[2] = 8'hAD;
        exp_b[3] = 8'hDE;
        issue(1'b1, 1'b0, 32'h0000_0020, 32'hDEAD_BEEF);
        tick();
        req_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            check("ws_mem_we", {31'b0, mem_we}, 32'd1);
            check("ws_mem_A", mem_A, 32'h20 + b);
            check("ws_mem_WD", {24'b0, mem_WD}, {24'b0, exp_b[b]});
            tick();
        end
        check("ws_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("ws_rsp_rd", rsp_rd, 32'd0);
        check("ws_we_off", {31'b0, mem_we}, 32'd0);
        tick();
        check("ws_mem_20", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]},
              32'hDEAD_BEEF);

        // Load the stored word back
        issue(1'b0, 1'b0, 32'h0000_0020, 32'h0);
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        check("wl2_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("wl2_rsp_rd", rsp_rd, 32'hDEAD_BEEF);
        tick();

        // Address wrap
        exp_a[0] = 32'hFFFF_FFFE;
        exp_a[1] = 32'hFFFF_FFFF;
        exp_a[2] = 32'h0000_0000;
        exp_a[3] = 32'h0000_0001;
        issue(1'b0, 1'b0, 32'hFFFF_FFFE, 32'h0);
        tick();
        req_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            check("wrap_mem_A", mem_A, exp_a[b]);
            tick();
        end
        check("wrap_rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("wrap_rsp_rd", rsp_rd, 32'h2211_BBAA);
        tick();

        // Reset after the second beat of a word store to 0x40
        issue(1'b1, 1'b0, 32'h0000_0040, 32'h1234_5678);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        check("mr_third_beat_we", {31'b0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_we_forced", {31'b0, mem_we}, 32'd0);
        check("mr_ready", {31'b0, req_ready}, 32'd1);
        check("mr_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("mr_no_rsp", {31'b0, rsp_valid}, 32'd0);
            check("mr_idle_ready", {31'b0, req_ready}, 32'd1);
            tick();
        end
        check("mr_mem_40", {24'b0, mem[8'h40]}, 32'h78);
        check("mr_mem_41", {24'b0, mem[8'h41]}, 32'h56);
        check("mr_mem_42", {24'b0, mem[8'h42]}, 32'h00);
        check("mr_mem_43", {24'b0, mem[8'h43]}, 32'h00);

        // Back-to-back: byte load then word load, req_valid held high
        issue(1'b0, 1'b1, 32'h0001_0002, 32'h0);
        check("bb_ready_c0", {31'b0, req_ready}, 32'd1);
        tick();
        issue(1'b0, 1'b0, 32'h0001_0000, 32'h0);
        check("bb_ready_c1", {31'b0, req_ready}, 32'd0);
        check("bb_mem_A_c1", mem_A, 32'h0001_0002);
        tick();
        check("bb_ready_c2", {31'b0, req_ready}, 32'd0);
        check("bb_rsp_c2", {31'b0, rsp_valid}, 32'd1);
        check("bb_rd_c2", rsp_rd, 32'h0000_0033);
        tick();
        check("bb_ready_c3", {31'b0, req_ready}, 32'd1);
        check("bb_no_rsp_c3", {31'b0, rsp_valid}, 32'd0);
        tick();
        req_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            check("bb_ready_xfer", {31'b0, req_ready}, 32'd0);
            check("bb_mem_A", mem_A, 32'h0001_0000 + b);
            check("bb_no_rsp", {31'b0, rsp_valid}, 32'd0);
            tick();
        end
        check("bb_rsp_c8", {31'b0, rsp_valid}, 32'd1);
        check("bb_rd_c8", rsp_rd, 32'h4433_2211);
        check("bb_ready_c8", {31'b0, req_ready}, 32'd0);
        tick();
        for (int c = 0; c < 4; c++) begin
            check("bb_no_dup", {31'b0, rsp_valid}, 32'd0);
            check("bb_idle", {31'b0, req_ready}, 32'd1);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side memory access unit for the pipelined RISC-V core, sitting between the MEM-stage pipeline logic and the byte-organised DataMemory. It accepts one load or store request at a time from the pipeline over a valid/ready handshake. It serialises the request into byte-wide memory beats: one beat for a byte access, four for a word access. It then returns assembled load data, or a store completion, as a single-cycle response pulse.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, byte address width
- DATA_WIDTH, 32, pipeline data width (word = 4 bytes)
- STORE_WIDTH, 8, memory beat width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  pipeline presents a request
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- addr_modeM  in  1  1 = byte access, 0 = word access
- req_addr  in  ADDRESS_WIDTH  byte address of access
- req_wd  in  DATA_WIDTH  store data; byte mode uses [7:0]
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rd  out  DATA_WIDTH  load result; byte load zero-extended; 0 for stores
- mem_we  out  1  memory write enable for the current beat
- mem_A  out  ADDRESS_WIDTH  memory byte address for the current beat
- mem_WD  out  STORE_WIDTH  memory write byte
- mem_RD  in  STORE_WIDTH  memory read byte (combinational from mem_A)

## Operation
- States: IDLE, XFER, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid: latch req_we, addr_modeM, req_addr, req_wd.
  - Clear beat counter and rdata register; go to XFER.
- XFER:
  - mem_A = latched_addr + beat, truncated to ADDRESS_WIDTH (wraps 0xFFFFFFFF→0x0).
  - mem_WD = latched_wd[8*beat+7 : 8*beat].
  - mem_we = latched_we.
  - Each cycle: on loads, capture mem_RD into rdata byte[beat]; increment beat.
  - Last beat (beat==0 in byte mode, beat==3 in word mode) → RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle.
  - rsp_rd = assembled little-endian word, or {24'b0, byte} in byte mode; 0 for stores.
  - Next state is IDLE.
- Misaligned word addresses are legal; no alignment exception.
- No response back-pressure; the pipeline must consume the rsp_valid pulse.
- Outside XFER: mem_we=0, mem_A=0, mem_WD=0.
- req_valid is ignored outside IDLE; the request is not latched.

## Timing
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - rsp_valid=0, rsp_rd=0, mem_we=0, mem_A=0, mem_WD=0.
  - req_ready=1 while in IDLE, including during reset.
- Accept happens on the rising edge where req_valid && req_ready (cycle 0).
- Byte access: XFER at cycle 1, rsp_valid at cycle 2; next accept possible at edge ending cycle 3.
- Word access: XFER at cycles 1–4 (addr, +1, +2, +3), rsp_valid at cycle 5.
- Store bytes commit in memory at the rising edge ending each XFER cycle.
- Reset mid-XFER:
  - Immediate return to IDLE with mem_we forced low asynchronously.
  - Store bytes already committed remain in memory.
  - No rsp_valid is issued.
- Back-to-back requests: req_valid held high through RESP is accepted in the following IDLE cycle; no request is lost or duplicated.

## Structure
- Package lsu_pkg: state enum (IDLE, XFER, RESP), BEATS_WORD=4, BEATS_BYTE=1, 2-bit beat type.
- Single module; no sub-module is warranted.
- FSM, beat counter, request latch and rdata register are all local to load_store_unit.

## Test plan
- Word load: memory preloaded 0x10000..0x10003 = 11,22,33,44; word load @0x10000.
  - mem_A steps 0x10000..0x10003 on cycles 1–4.
  - rsp_valid at cycle 5 with rsp_rd=0x44332211.
- Byte load: @0x10002 → single beat; rsp_rd=0x00000033 at cycle 2.
- Word store: 0xDEADBEEF @0x20 → mem_WD EF,BE,AD,DE with mem_we=1 on cycles 1–4; rsp_rd=0. A following word load @0x20 returns 0xDEADBEEF.
- Wrap: word load @0xFFFFFFFE → mem_A = FFFFFFFE, FFFFFFFF, 00000000, 00000001.
- Reset after the second beat of a word store to 0x40:
  - Only 0x40 and 0x41 are modified.
  - rsp_valid never asserts.
  - req_ready=1 immediately after reset.
- Back-to-back: req_valid held high with byte load then word load → req_ready low during XFER/RESP; two rsp_valid pulses at cycles 2 and 8.
